// File: rtl/mem_arbiter.sv
// Two-port arbiter for the main-memory data port: port C (core) and port D (debug/loader).
// Optional D anti-starvation counter is enabled with `define ARB_FAIRNESS_EN.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_lock,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  input  logic [1:0]    c_width,
  output logic          c_gnt,
  output logic [DW-1:0] c_rdata,
  output logic          c_rvalid,
  input  logic          d_req,
  input  logic          d_lock,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [1:0]    d_width,
  output logic          d_gnt,
  output logic [DW-1:0] d_rdata,
  output logic          d_rvalid,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_we,
  output logic [1:0]    m_width,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_C, OWN_D} own_t;

  typedef struct packed {
    logic [1:0]    width;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mfld_t;

  own_t  lock_q, lock_d;
  own_t  tag_q, tag_d;
  mfld_t c_fld, d_fld, sel_fld, shadow_q;
  logic  starve;

  assign c_fld = '{width: c_width, addr: c_addr, wdata: c_wdata};
  assign d_fld = '{width: d_width, addr: d_addr, wdata: d_wdata};

`ifdef ARB_FAIRNESS_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  logic [2:0] starve_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 starve_cnt <= '0;
    else if (!d_req || d_gnt)  starve_cnt <= '0;
    else if (starve_cnt != 3'd7) starve_cnt <= starve_cnt + 3'd1;
  end

  assign starve = (starve_cnt == STARVE_LIM);
`else
  // Pure fixed priority; STARVE_MAX has no effect in this build.
  assign starve = 1'b0 & (STARVE_MAX != 0);
`endif

  // Arbitration: held lock first, then forced D on starvation, then C over D.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (lock_q == OWN_C && c_req)      c_gnt = 1'b1;
    else if (lock_q == OWN_D && d_req) d_gnt = 1'b1;
    else if (d_req && starve)          d_gnt = 1'b1;
    else if (c_req)                    c_gnt = 1'b1;
    else if (d_req)                    d_gnt = 1'b1;
    if (reset) begin
      c_gnt = 1'b0;
      d_gnt = 1'b0;
    end
  end

  always_comb begin
    lock_d  = OWN_NONE;
    tag_d   = OWN_NONE;
    sel_fld = shadow_q;
    m_we    = 1'b0;
    if (c_gnt) begin
      sel_fld = c_fld;
      m_we    = c_we;
      if (c_lock) lock_d = OWN_C;
      if (!c_we)  tag_d  = OWN_C;
    end else if (d_gnt) begin
      sel_fld = d_fld;
      m_we    = d_we;
      if (d_lock) lock_d = OWN_D;
      if (!d_we)  tag_d  = OWN_D;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q   <= OWN_NONE;
      tag_q    <= OWN_NONE;
      shadow_q <= '0;
    end else begin
      lock_q <= lock_d;
      tag_q  <= tag_d;
      if (c_gnt || d_gnt) shadow_q <= sel_fld;
    end
  end

  assign m_addr  = sel_fld.addr;
  assign m_wdata = sel_fld.wdata;
  assign m_width = sel_fld.width;

  assign c_rvalid = (tag_q == OWN_C);
  assign d_rvalid = (tag_q == OWN_D);
  assign c_rdata  = c_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, read return, collision,
// lock, fairness (either build) and pipelined alternating reads.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          c_req, c_lock, c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [1:0]    c_width;
  logic          c_gnt, c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          d_req, d_lock, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [1:0]    d_width;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  logic [1:0]    m_width;
  logic [DW-1:0] m_rdata;

  int checks;
  int failures;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_lock(c_lock), .c_we(c_we), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_width(c_width), .c_gnt(c_gnt), .c_rdata(c_rdata),
    .c_rvalid(c_rvalid),
    .d_req(d_req), .d_lock(d_lock), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_width(d_width), .d_gnt(d_gnt), .d_rdata(d_rdata),
    .d_rvalid(d_rvalid),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_width(m_width),
    .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_req = 0; c_lock = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_width = 2'b10;
    d_req = 0; d_lock = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_width = 2'b10;
  endtask

  int dcnt;

  initial begin
    checks = 0; failures = 0;
    idle();
    m_rdata = '0;
    reset = 1;
    c_req = 1;
    #2;
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_width", m_width, 0);
    step();
    chk("rst_edge_c_gnt", c_gnt, 0);
    reset = 0;
    #1;
    chk("rel_c_gnt", c_gnt, 1);
    step();
    idle();
    step();

    // Read path
    c_req = 1; c_addr = 32'h10;
    #1;
    chk("rd_c_gnt", c_gnt, 1);
    chk("rd_m_addr", m_addr, 32'h10);
    chk("rd_m_we", m_we, 0);
    step();
    idle();
    m_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_c_rvalid", c_rvalid, 1);
    chk("rd_c_rdata", c_rdata, 32'hDEADBEEF);
    chk("rd_d_rvalid", d_rvalid, 0);
    chk("rd_d_rdata", d_rdata, 0);
    step();
    chk("rd_one_shot", c_rvalid, 0);

    // Collision: C read vs D byte write
    c_req = 1; c_addr = 32'h30;
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h55; d_width = 2'b00;
    #1;
    chk("col_c_gnt", c_gnt, 1);
    chk("col_d_gnt0", d_gnt, 0);
    chk("col_m_addr0", m_addr, 32'h30);
    step();
    c_req = 0;
    m_rdata = 32'h1234_5678;
    #1;
    chk("col_d_gnt", d_gnt, 1);
    chk("col_m_we", m_we, 1);
    chk("col_m_addr", m_addr, 32'h20);
    chk("col_m_wdata", m_wdata, 32'h55);
    chk("col_m_width", m_width, 2'b00);
    chk("col_c_rvalid", c_rvalid, 1);
    chk("col_c_rdata", c_rdata, 32'h1234_5678);
    step();
    idle();
    #1;
    chk("wr_no_rvalid", d_rvalid, 0);
    chk("idle_m_we", m_we, 0);
    chk("idle_m_addr_hold", m_addr, 32'h20);
    chk("idle_m_width_hold", m_width, 2'b00);
    step();

    // Lock held by D across C requests
    d_req = 1; d_lock = 1; d_addr = 32'h80;
    #1;
    chk("lk_d_gnt0", d_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      c_req = 1; c_addr = 32'h90;
      #1;
      chk($sformatf("lk_d_gnt%0d", i + 1), d_gnt, 1);
      chk($sformatf("lk_c_gnt%0d", i + 1), c_gnt, 0);
    end
    step();
    d_req = 0; d_lock = 0;
    #1;
    chk("lk_rel_c_gnt", c_gnt, 1);
    chk("lk_rel_m_addr", m_addr, 32'h90);
    step();
    idle();
    step();

    // Lock taken, then both requesters drop: released, no access
    d_req = 1; d_lock = 1; d_addr = 32'hA0;
    step();
    idle();
    #1;
    chk("drop_c_gnt", c_gnt, 0);
    chk("drop_d_gnt", d_gnt, 0);
    chk("drop_m_we", m_we, 0);
    step();
    c_req = 1; d_req = 1;
    #1;
    chk("drop_after_c_gnt", c_gnt, 1);
    step();
    idle();
    step();

    // Reset mid-operation: lock cleared, pending rvalid suppressed
    d_req = 1; d_lock = 1;
    step();
    c_req = 1; c_addr = 32'h40;
    #1;
    chk("mid_d_gnt", d_gnt, 1);
    reset = 1;
    #1;
    chk("mid_rst_d_gnt", d_gnt, 0);
    chk("mid_rst_m_addr", m_addr, 0);
    step();
    chk("mid_rst_d_rvalid", d_rvalid, 0);
    reset = 0;
    #1;
    chk("mid_rst_lock_clr", c_gnt, 1);
    step();
    idle();
    step();

    // Fairness under continuous contention
    c_req = 1; d_req = 1; d_addr = 32'hB0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
`ifdef ARB_FAIRNESS_EN
      chk($sformatf("fair_d_gnt%0d", i), d_gnt, (i % 5 == 4) ? 1 : 0);
      chk($sformatf("fair_c_gnt%0d", i), c_gnt, (i % 5 == 4) ? 0 : 1);
`else
      chk($sformatf("fix_d_gnt%0d", i), d_gnt, 0);
`endif
      if (d_gnt) dcnt++;
      step();
    end
`ifdef ARB_FAIRNESS_EN
    chk("fair_d_total", dcnt, 4);
`else
    chk("fix_d_total", dcnt, 0);
`endif
    idle();
    step();
    step();

    // Pipelined alternating reads C,D,C,D
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 4) begin
        if (i % 2 == 0) begin c_req = 1; c_addr = 32'h100 + 4 * i; end
        else            begin d_req = 1; d_addr = 32'h100 + 4 * i; end
      end
      m_rdata = 32'hA0 + i;
      #1;
      if (i < 4) begin
        chk($sformatf("pl_c_gnt%0d", i), c_gnt, (i % 2 == 0) ? 1 : 0);
        chk($sformatf("pl_d_gnt%0d", i), d_gnt, (i % 2 == 1) ? 1 : 0);
        chk($sformatf("pl_m_addr%0d", i), m_addr, 32'h100 + 4 * i);
      end
      if (i > 0) begin
        chk($sformatf("pl_c_rvalid%0d", i), c_rvalid, ((i - 1) % 2 == 0) ? 1 : 0);
        chk($sformatf("pl_d_rvalid%0d", i), d_rvalid, ((i - 1) % 2 == 1) ? 1 : 0);
        chk($sformatf("pl_c_rdata%0d", i), c_rdata, ((i - 1) % 2 == 0) ? 32'hA0 + i : 0);
        chk($sformatf("pl_d_rdata%0d", i), d_rdata, ((i - 1) % 2 == 1) ? 32'hA0 + i : 0);
      end
      step();
    end
    idle();
    #1;
    chk("pl_end_c_rvalid", c_rvalid, 0);
    chk("pl_end_d_rvalid", d_rvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
